// File: rtl/enable_controller_pkg.sv
// Shared types and the fixed ten-slot enable schedule that the checker
// compares incoming strobes against.
package enable_controller_pkg;

  localparam int NUM_EN    = 10;
  localparam int FRAME_LEN = 10;

  typedef logic [3:0] slot_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_t;

  // Slot 3 carries both enable2 and enable3; every other slot has one strobe.
  localparam logic [NUM_EN-1:0] EXP_PATTERN [FRAME_LEN] = '{
    10'h001, 10'h002, 10'h004, 10'h00C, 10'h010,
    10'h020, 10'h040, 10'h080, 10'h100, 10'h200
  };

  localparam slot_t LAST_SLOT = slot_t'(FRAME_LEN - 1);

  // Out-of-range slots map to all-zero instead of indexing past the table.
  function automatic logic [NUM_EN-1:0] exp_at(input slot_t s);
    logic [NUM_EN-1:0] e;
    e = '0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (s == slot_t'(i)) e = EXP_PATTERN[i];
    end
    return e;
  endfunction

endpackage

// File: rtl/enable_sat_counter.sv
// Saturating up-counter with a synchronous clear that beats increment.
module enable_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/enable_sequence_checker.sv
// Receive-side checker: locks onto the ten-strobe enable frame, flags slot
// mismatches and keeps saturating clean-frame and error counts.
//
//   state | meaning
//   IDLE  | unlocked, waiting for an EXP(0) sample; never flags errors
//   TRACK | locked, slot_q names the slot the next sample must match
module enable_sequence_checker
  import enable_controller_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int ERR_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              check_en_i,
  input  logic              clear_i,
  input  logic [NUM_EN-1:0] enable_i,
  output logic              in_sync_o,
  output logic              error_o,
  output logic [3:0]        err_slot_o,
  output logic [NUM_EN-1:0] err_mask_o,
  output logic [CNT_W-1:0]  frame_count_o,
  output logic [ERR_W-1:0]  error_count_o
);

  state_t            state_q, state_d;
  slot_t             slot_q, slot_d;
  logic              error_q, error_d;
  slot_t             err_slot_q, err_slot_d;
  logic [NUM_EN-1:0] err_mask_q, err_mask_d;
  logic              frame_inc, err_inc;
  logic [NUM_EN-1:0] exp_cur;
  logic              slot_match, is_start;

  assign exp_cur    = exp_at(slot_q);
  assign slot_match = (enable_i == exp_cur);
  assign is_start   = (enable_i == EXP_PATTERN[0]);

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    error_d    = 1'b0;
    err_slot_d = err_slot_q;
    err_mask_d = err_mask_q;
    frame_inc  = 1'b0;
    err_inc    = 1'b0;

    if (!check_en_i) begin
      state_d = IDLE;
      slot_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (is_start) begin
            state_d = TRACK;
            slot_d  = slot_t'(1);
          end
        end
        TRACK: begin
          if (slot_match) begin
            if (slot_q == LAST_SLOT) begin
              slot_d    = '0;
              frame_inc = 1'b1;
            end else begin
              slot_d = slot_q + slot_t'(1);
            end
          end else begin
            error_d    = 1'b1;
            err_slot_d = slot_q;
            err_mask_d = enable_i ^ exp_cur;
            err_inc    = 1'b1;
            // A mismatching sample that is itself a frame start relocks at once.
            if (is_start) begin
              state_d = TRACK;
              slot_d  = slot_t'(1);
            end else begin
              state_d = IDLE;
              slot_d  = '0;
            end
          end
        end
        default: begin
          state_d = IDLE;
          slot_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      error_q    <= 1'b0;
      err_slot_q <= '0;
      err_mask_q <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      error_q    <= error_d;
      err_slot_q <= err_slot_d;
      err_mask_q <= err_mask_d;
    end
  end

  enable_sat_counter #(.W(CNT_W)) u_frame_cnt (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clr_i    (clear_i),
    .inc_i    (frame_inc),
    .cnt_o    (frame_count_o)
  );

  enable_sat_counter #(.W(ERR_W)) u_error_cnt (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clr_i    (clear_i),
    .inc_i    (err_inc),
    .cnt_o    (error_count_o)
  );

  assign in_sync_o  = (state_q == TRACK);
  assign error_o    = error_q;
  assign err_slot_o = err_slot_q;
  assign err_mask_o = err_mask_q;

endmodule

// File: tb/tb_enable_sequence_checker.sv
// Directed bench for enable_sequence_checker: a default instance and an
// ERR_W=2 instance share stimulus and are compared each cycle to a model.
module tb_enable_sequence_checker;

  logic       clk = 1'b0;
  logic       reset_ni = 1'b1;
  logic       check_en = 1'b1;
  logic       clear = 1'b0;
  logic [9:0] en = '0;
  bit         cmp_on = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  logic       a_sync, a_err, b_sync, b_err;
  logic [3:0] a_eslot, b_eslot;
  logic [9:0] a_emask, b_emask;
  logic [15:0] a_frames, b_frames;
  logic [7:0] a_errs;
  logic [1:0] b_errs;

  always #5 clk = ~clk;

  enable_sequence_checker dut_a (
    .clk_i(clk), .reset_ni(reset_ni), .check_en_i(check_en), .clear_i(clear),
    .enable_i(en), .in_sync_o(a_sync), .error_o(a_err), .err_slot_o(a_eslot),
    .err_mask_o(a_emask), .frame_count_o(a_frames), .error_count_o(a_errs)
  );

  enable_sequence_checker #(.CNT_W(16), .ERR_W(2)) dut_b (
    .clk_i(clk), .reset_ni(reset_ni), .check_en_i(check_en), .clear_i(clear),
    .enable_i(en), .in_sync_o(b_sync), .error_o(b_err), .err_slot_o(b_eslot),
    .err_mask_o(b_emask), .frame_count_o(b_frames), .error_count_o(b_errs)
  );

  // Schedule from the rules: one strobe per slot, slot 3 also keeps enable2.
  function automatic logic [9:0] exp_of(input int s);
    if (s == 3) return 10'h00C;
    return 10'd1 << s;
  endfunction

  // Behavioural model: integer slot position plus saturating integer counts.
  bit         m_sync = 0;
  int         m_pos = 0;
  bit         m_err = 0;
  int         m_eslot = 0;
  logic [9:0] m_emask = '0;
  int         m_frames = 0, m_errs_a = 0, m_errs_b = 0;

  always @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      m_sync = 0; m_pos = 0; m_err = 0; m_eslot = 0; m_emask = '0;
      m_frames = 0; m_errs_a = 0; m_errs_b = 0;
    end else begin
      bit f_inc, e_inc;
      f_inc = 0; e_inc = 0; m_err = 0;
      if (!check_en) begin
        m_sync = 0; m_pos = 0;
      end else if (!m_sync) begin
        if (en == exp_of(0)) begin m_sync = 1; m_pos = 1; end
      end else if (en == exp_of(m_pos)) begin
        m_pos = (m_pos + 1) % 10;
        if (m_pos == 0) f_inc = 1;
      end else begin
        m_err = 1; e_inc = 1;
        m_eslot = m_pos;
        m_emask = en ^ exp_of(m_pos);
        if (en == exp_of(0)) m_pos = 1;
        else begin m_sync = 0; m_pos = 0; end
      end
      if (clear) begin
        m_frames = 0; m_errs_a = 0; m_errs_b = 0;
      end else begin
        if (f_inc && m_frames < 65535) m_frames++;
        if (e_inc && m_errs_a < 255) m_errs_a++;
        if (e_inc && m_errs_b < 3) m_errs_b++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      check("a_in_sync", 32'(a_sync), 32'(m_sync));
      check("a_error", 32'(a_err), 32'(m_err));
      check("a_err_slot", 32'(a_eslot), 32'(m_eslot));
      check("a_err_mask", 32'(a_emask), 32'(m_emask));
      check("a_frames", 32'(a_frames), 32'(m_frames));
      check("a_errs", 32'(a_errs), 32'(m_errs_a));
      check("b_in_sync", 32'(b_sync), 32'(m_sync));
      check("b_error", 32'(b_err), 32'(m_err));
      check("b_err_mask", 32'(b_emask), 32'(m_emask));
      check("b_frames", 32'(b_frames), 32'(m_frames));
      check("b_errs", 32'(b_errs), 32'(m_errs_b));
    end
  end

  // Called at negedge+1; returns at the next negedge+1 with the result visible.
  task automatic drive(input logic [9:0] v);
    en = v;
    @(negedge clk);
    #1;
  endtask

  task automatic drive_slots(input int first, input int last);
    for (int s = first; s <= last; s++) drive(exp_of(s));
  endtask

  initial begin
    @(negedge clk);
    #1;
    reset_ni = 1'b0;
    cmp_on   = 1'b1;
    repeat (3) drive(10'h000);
    reset_ni = 1'b1;

    repeat (20) drive(10'h000);
    check("idle_in_sync", 32'(a_sync), 32'd0);
    check("idle_frames", 32'(a_frames), 32'd0);
    check("idle_error", 32'(a_err), 32'd0);

    drive(10'h001);
    check("lock_in_sync", 32'(a_sync), 32'd1);
    drive_slots(1, 9);
    drive_slots(0, 9);
    drive_slots(0, 9);
    check("three_frames", 32'(a_frames), 32'd3);
    check("three_frames_errs", 32'(a_errs), 32'd0);

    drive_slots(0, 2);
    drive(10'h008);
    check("drop3_error", 32'(a_err), 32'd1);
    check("drop3_slot", 32'(a_eslot), 32'd3);
    check("drop3_mask", 32'(a_emask), 32'h004);
    check("drop3_errs", 32'(a_errs), 32'd1);
    check("drop3_in_sync", 32'(a_sync), 32'd0);
    drive(10'h000);
    check("drop3_single_pulse", 32'(a_err), 32'd0);
    drive_slots(0, 9);
    check("resync_frames", 32'(a_frames), 32'd4);

    drive_slots(0, 4);
    drive(10'h001);
    check("slot5_mask", 32'(a_emask), 32'h021);
    check("slot5_slot", 32'(a_eslot), 32'd5);
    check("slot5_in_sync", 32'(a_sync), 32'd1);
    drive_slots(1, 9);
    drive(10'h001);
    check("slot5_next_frame", 32'(a_frames), 32'd5);

    repeat (5) begin
      drive(10'h001);
      check("b2b_error", 32'(a_err), 32'd1);
    end
    check("sat_b_errs", 32'(b_errs), 32'd3);
    check("a_errs_7", 32'(a_errs), 32'd7);
    clear = 1'b1;
    drive(10'h001);
    clear = 1'b0;
    check("clear_wins_a", 32'(a_errs), 32'd0);
    check("clear_wins_b", 32'(b_errs), 32'd0);
    check("clear_error_pulse", 32'(a_err), 32'd1);

    drive_slots(1, 9);
    check("post_clear_frame", 32'(a_frames), 32'd1);
    drive_slots(0, 5);
    reset_ni = 1'b0;
    #1;
    check("rst_in_sync", 32'(a_sync), 32'd0);
    check("rst_frames", 32'(a_frames), 32'd0);
    check("rst_mask", 32'(a_emask), 32'd0);
    check("rst_slot", 32'(a_eslot), 32'd0);
    drive(exp_of(6));
    drive(exp_of(7));
    reset_ni = 1'b1;
    drive_slots(8, 9);
    check("rst_no_error", 32'(a_errs), 32'd0);
    check("rst_idle", 32'(a_sync), 32'd0);
    drive_slots(0, 9);
    check("rst_relock_frame", 32'(a_frames), 32'd1);

    drive_slots(0, 3);
    check_en = 1'b0;
    drive(exp_of(4));
    check("en_off_in_sync", 32'(a_sync), 32'd0);
    check("en_off_error", 32'(a_err), 32'd0);
    drive(exp_of(5));
    check_en = 1'b1;
    drive_slots(6, 9);
    check("en_off_no_errs", 32'(a_errs), 32'd0);
    drive_slots(0, 9);
    check("en_relock_frame", 32'(a_frames), 32'd2);

    clear = 1'b1;
    drive(10'h000);
    clear = 1'b0;
    check("idle_clear", 32'(a_frames), 32'd0);

    cmp_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
